instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immediate-extraction stage: packs opcode, register fields, funct3 and a full 32-bit immediate into a standard RV32I instruction word.
- Covers the I_type_op, I_type_ld, U, B, J and S formats.
- Used by the self-test/boot-stub generator and the bench stimulus path to feed the fetch side.
- Input is a valid/ready handshake; output is a registered 2-entry FIFO with valid/ready.

Parameters:
- DEPTH, 2, output FIFO entries; only 2 is supported.
- NOP_WORD, 32'h00000013, word emitted for an unsupported opcode.

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  field set on inputs is valid
- ready_out  output  1  encoder can accept this cycle
- opcode_in  input  7  instruction opcode [6:0]
- rd_in  input  5  destination register
- rs1_in  input  5  source register 1
- rs2_in  input  5  source register 2
- funct3_in  input  3  funct3
- imm_in  input  32  full sign-extended immediate value; U-type uses the value with [11:0]=0
- valid_out  output  1  instr_out holds a word
- ready_in  input  1  consumer takes the word this cycle
- instr_out  output  32  encoded instruction (FIFO head)
- illegal_out  output  1  head word came from an unsupported opcode
- err_out  output  1  head word failed the immediate range check (optional feature)

Behaviour:
- Reset (async, rst_n_in=0): FIFO empty, pointers and count 0, valid_out=0, instr_out=0, illegal_out=0, err_out=0, ready_out=1 once released.
- Accept when valid_in && ready_out. The word is encoded combinationally and written to the FIFO tail on that edge.
- valid_out rises the next cycle, so latency is 1 cycle when the FIFO was empty.
- Pop when valid_out && ready_in; the head advances on that edge.
- ready_out = (count < 2) and depends only on registered state. There is no combinational path from ready_in to ready_out.
- When full with a simultaneous pop, the new input is not accepted that cycle.
- Simultaneous push and pop with count=1: count stays 1, the head becomes the new word on the next cycle.
- Pointers are 1 bit and wrap 1->0. count ranges 0..2.
- Pop while empty is ignored. Push while full cannot occur, because ready_out=0.
- Field placement: opcode [6:0]; rd [11:7] for I/U/J; funct3 [14:12] for I/S/B; rs1 [19:15] for I/S/B; rs2 [24:20] for S/B.
- I (0010011, 0000011): [31:20]=imm[11:0].
- S (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0].
- B (1100011): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- U (0110111): [31:12]=imm[31:12].
- J (1101111): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Fields unused by a format are not encoded.
- Any other opcode: word=NOP_WORD, illegal flag=1, stored alongside the word.
- Flags travel with their FIFO entry and are valid only while valid_out=1; they read 0 when empty.
- Reset asserted mid-transfer: all FIFO contents are discarded immediately.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- With the macro defined, the encoder sets the err flag stored with the entry when the immediate does not fit its format:
  - I/S: not representable as a signed 12-bit value.
  - B: not a signed 13-bit value, or imm[0]=1.
  - J: not a signed 21-bit value, or imm[20..0] range violated, or imm[0]=1.
  - U: imm[11:0] != 0.
- On an err, the word is still encoded with truncated bits.
- Without the macro: no check logic is built, and err_out is tied to 0.

Test Plan:
- Reset, then addi: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> ready_out=1; valid_out=1 one cycle after accept; instr_out=0x00500093, illegal_out=0.
- sw: opcode=0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423. beq: opcode=1100011, rs1=rs2=0, imm=-4 -> 0xFE000EE3.
- jal: rd=1, imm=8 -> 0x008000EF. lui: rd=5, imm=0x12345000 -> 0x123452B7.
- Backpressure: ready_in=0, push 3 words -> ready_out=0 after the 2nd accept. Set ready_in=1 -> words drain in order and the 3rd is accepted only once count<2.
- Opcode=0110011 -> instr_out=0x00000013, illegal_out=1.
- With IMM_RANGE_CHECK_EN: I-type imm=2048 -> err_out=1. beq imm=3 -> err_out=1. Without the macro -> err_out=0.
- Reset mid-stream: assert rst_n_in=0 with 2 words queued -> valid_out=0 and instr_out=0 immediately; after release ready_out=1 and the FIFO is empty.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs opcode/register/funct3/immediate fields into RV32I words (I, S, B, U, J); IMM_RANGE_CHECK_EN adds the immediate range check.
// Latency: 1 cycle from accept to valid_out when the 2-entry output FIFO is empty.
// Backpressure: ready_out drops while the FIFO holds 2 entries and depends only on registered count.
module instr_encoder #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic [6:0]  opcode_in,
   input  logic [4:0]  rd_in,
   input  logic [4:0]  rs1_in,
   input  logic [4:0]  rs2_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] imm_in,
   output logic        valid_out,
   input  logic        ready_in,
   output logic [31:0] instr_out,
   output logic        illegal_out,
   output logic        err_out
);

   localparam logic [6:0] OP_I_ALU = 7'b0010011;
   localparam logic [6:0] OP_I_LD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_U     = 7'b0110111;
   localparam logic [6:0] OP_J     = 7'b1101111;

   typedef struct packed {
      logic [31:0] word;
      logic        ill;
      logic        err;
   } entry_t;

   entry_t     enc_d;
   entry_t     mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       push;
   logic       pop;

   always_comb begin
      enc_d      = '0;
      enc_d.word = NOP_WORD;
      case (opcode_in)
         OP_I_ALU, OP_I_LD:
            enc_d.word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
         OP_S:
            enc_d.word = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
         OP_B:
            enc_d.word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                          imm_in[4:1], imm_in[11], opcode_in};
         OP_U:
            enc_d.word = {imm_in[31:12], rd_in, opcode_in};
         OP_J:
            enc_d.word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, opcode_in};
         default:
            enc_d.ill  = 1'b1;
      endcase
`ifdef IMM_RANGE_CHECK_EN
      // A value fits a signed N-bit field when bits [31:N-1] are all equal.
      case (opcode_in)
         OP_I_ALU, OP_I_LD, OP_S:
            enc_d.err = !(&imm_in[31:11] || !(|imm_in[31:11]));
         OP_B:
            enc_d.err = !(&imm_in[31:12] || !(|imm_in[31:12])) || imm_in[0];
         OP_J:
            enc_d.err = !(&imm_in[31:20] || !(|imm_in[31:20])) || imm_in[0];
         OP_U:
            enc_d.err = |imm_in[11:0];
         default:
            enc_d.err = 1'b0;
      endcase
`endif
   end

   assign ready_out = (count_q < 2'(DEPTH));
   assign valid_out = (count_q != 2'd0);
   assign push      = valid_in && ready_out;
   assign pop       = valid_out && ready_in;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= enc_d;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Stale entries stay in storage after a pop, so gate the head with valid.
   assign instr_out   = valid_out ? mem_q[rd_ptr_q].word : 32'h0;
   assign illegal_out = valid_out && mem_q[rd_ptr_q].ill;
`ifdef IMM_RANGE_CHECK_EN
   assign err_out     = valid_out && mem_q[rd_ptr_q].err;
`else
   assign err_out     = 1'b0;
`endif

endmodule
